// File: rtl/rr_burst_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package rr_arb_pkg;

    typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;

    // Wrap-around increment of a requester index in the range 0..cnt-1.
    function automatic int next_ptr(input int idx, input int cnt);
        return (idx >= cnt - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_burst_arb_if.sv
// Requester/resource side bundle of the burst arbiter; slave = arbiter, master = requesters/resource.
interface rr_burst_arb_if #(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT)
);
    logic [REQCNT-1:0]   req_i;
    logic [REQCNT-1:0]   last_i;
    logic                res_ready_i;
    logic [REQCNT-1:0]   gnt_o;
    logic [REQWIDTH-1:0] gnt_num_o;
    logic                gnt_val_o;
    logic                beat_o;
    logic                abort_o;

    modport slave (
        input  req_i, last_i, res_ready_i,
        output gnt_o, gnt_num_o, gnt_val_o, beat_o, abort_o
    );

    modport master (
        output req_i, last_i, res_ready_i,
        input  gnt_o, gnt_num_o, gnt_val_o, beat_o, abort_o
    );
endinterface

// File: rtl/rr_burst_arb_pick.sv
// Combinational rotating-priority finder: first set request at or after ptr, wrapping.
// Zero latency; no flow control.
module rr_pick #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_masked;

    // Upper copy supplies the wrapped candidates; lower copy is masked below ptr.
    always_comb begin
        w_dbl    = {req, req};
        w_masked = '0;
        for (int i = 0; i < 2*N; i++) begin
            w_masked[i] = w_dbl[i] && (i >= int'(ptr));
        end
    end

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 2*N - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                found = 1'b1;
                idx   = (i >= N) ? W'(i - N) : W'(i);
            end
        end
    end
endmodule

// File: rtl/rr_burst_arb.sv
// Round-robin burst arbiter: grant one cycle after request, held until last/withdraw/MAXBEATS.
// Beats only move when the resource is ready; a stalled resource holds the grant indefinitely.
module rr_burst_arb
    import rr_arb_pkg::*;
#(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int MAXBEATS = 16,
    parameter int BEATW    = $clog2(MAXBEATS + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    rr_burst_arb_if.slave  bus
);
    arb_state_t          r_state, w_state_n;
    logic [REQCNT-1:0]   r_gnt, w_gnt_n;
    logic [REQWIDTH-1:0] r_gnt_num, w_gnt_num_n;
    logic [REQWIDTH-1:0] r_ptr, w_ptr_n;
    logic                r_gnt_val, w_gnt_val_n;
    logic                r_abort, w_abort_n;
    logic [BEATW-1:0]    r_beat_cnt, w_beat_cnt_n;

    logic [REQWIDTH-1:0] w_pick_idx;
    logic                w_found;
    logic                w_owner_req;
    logic                w_owner_last;
    logic                w_beat;
    logic                w_max_rel;

    rr_pick #(.N(REQCNT), .W(REQWIDTH)) u_pick (
        .req   (bus.req_i),
        .ptr   (r_ptr),
        .idx   (w_pick_idx),
        .found (w_found)
    );

    assign w_owner_req  = bus.req_i[r_gnt_num];
    assign w_owner_last = bus.last_i[r_gnt_num];
    assign w_beat       = r_gnt_val & w_owner_req & bus.res_ready_i;
    // Forced release only when the owner did not end the burst on this same beat.
    assign w_max_rel    = w_beat & ~w_owner_last & (r_beat_cnt == BEATW'(MAXBEATS - 1));

    always_comb begin
        w_state_n    = r_state;
        w_gnt_n      = r_gnt;
        w_gnt_num_n  = r_gnt_num;
        w_gnt_val_n  = r_gnt_val;
        w_ptr_n      = r_ptr;
        w_beat_cnt_n = r_beat_cnt;
        w_abort_n    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_n              = BUSY;
                    w_gnt_n                = '0;
                    w_gnt_n[w_pick_idx]    = 1'b1;
                    w_gnt_num_n            = w_pick_idx;
                    w_gnt_val_n            = 1'b1;
                    w_beat_cnt_n           = '0;
                end
            end
            BUSY: begin
                if (!w_owner_req || (w_beat && w_owner_last) || w_max_rel) begin
                    w_state_n    = IDLE;
                    w_gnt_n      = '0;
                    w_gnt_num_n  = '0;
                    w_gnt_val_n  = 1'b0;
                    w_beat_cnt_n = '0;
                    w_abort_n    = w_max_rel;
                    w_ptr_n      = REQWIDTH'(next_ptr(int'(r_gnt_num), REQCNT));
                end else if (w_beat) begin
                    w_beat_cnt_n = r_beat_cnt + 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_num  <= '0;
            r_gnt_val  <= 1'b0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_gnt      <= w_gnt_n;
            r_gnt_num  <= w_gnt_num_n;
            r_gnt_val  <= w_gnt_val_n;
            r_ptr      <= w_ptr_n;
            r_beat_cnt <= w_beat_cnt_n;
            r_abort    <= w_abort_n;
        end
    end

    assign bus.gnt_o     = r_gnt;
    assign bus.gnt_num_o = r_gnt_num;
    assign bus.gnt_val_o = r_gnt_val;
    assign bus.beat_o    = w_beat;
    assign bus.abort_o   = r_abort;
endmodule

// File: tb/tb_rr_burst_arb.sv
// Scoreboard bench for rr_burst_arb: a request-level model predicts grants, beats, releases, aborts.
module tb_rr_burst_arb;
    localparam int N    = 5;
    localparam int MAXB = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    rr_burst_arb_if #(.REQCNT(N)) bus();

    rr_burst_arb #(.REQCNT(N), .MAXBEATS(MAXB)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int beats_seen = 0;
    int aborts_seen = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Model state: who owns the resource, beats so far, highest-priority index.
    int m_owner = -1;
    int m_ptr = 0;
    int m_beats = 0;
    int beat_q[$];
    int abort_q[$];
    int fall_q[$];
    int gq_cyc[$];
    int gq_idx[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_release(input bit forced);
        fall_q.push_back(cyc + 1);
        if (forced) abort_q.push_back(cyc + 1);
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_beats = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] rq;
        logic [N-1:0] lt;
        bit done;
        int i;
        rq = bus.req_i;
        lt = bus.last_i;
        done = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (!done && rq[i]) begin
                    done    = 1'b1;
                    m_owner = i;
                    m_beats = 0;
                    gq_cyc.push_back(cyc + 1);
                    gq_idx.push_back(i);
                end
            end
        end else if (!rq[m_owner]) begin
            model_release(1'b0);
        end else if (bus.res_ready_i) begin
            beat_q.push_back(cyc);
            m_beats++;
            if (lt[m_owner]) model_release(1'b0);
            else if (m_beats == MAXB) model_release(1'b1);
        end
    endtask

    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] lt, input logic rd);
        @(posedge clk_i);
        #1;
        bus.req_i       = rq;
        bus.last_i      = lt;
        bus.res_ready_i = rd;
        model_step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt_val"}, bus.gnt_val_o, 0);
        chk({tag, "_gnt"}, bus.gnt_o, 0);
        chk({tag, "_gnt_num"}, bus.gnt_num_o, 0);
        chk({tag, "_beat"}, bus.beat_o, 0);
        chk({tag, "_abort"}, bus.abort_o, 0);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i           = 1'b1;
        bus.req_i       = '0;
        bus.last_i      = '0;
        bus.res_ready_i = 1'b0;
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        beat_q.delete();
        abort_q.delete();
        fall_q.delete();
        gq_cyc.delete();
        gq_idx.delete();
        #1;
        check_zero("rst_async");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard queues.
    bit mon_prev_val = 1'b0;
    bit mon_eb, mon_ea, mon_ef, mon_newg, mon_fall;
    int mon_ei;
    always @(negedge clk_i) begin
        if (rst_i) begin
            mon_prev_val = 1'b0;
        end else begin
            mon_eb = beat_q.size() > 0 && beat_q[0] == cyc;
            if (mon_eb) void'(beat_q.pop_front());
            if (bus.beat_o) beats_seen++;
            chk("beat", bus.beat_o, mon_eb);

            mon_newg = bus.gnt_val_o && !mon_prev_val;
            mon_fall = !bus.gnt_val_o && mon_prev_val;
            if (gq_cyc.size() > 0 && gq_cyc[0] == cyc) begin
                mon_ei = gq_idx[0];
                void'(gq_cyc.pop_front());
                void'(gq_idx.pop_front());
                chk("grant_start", mon_newg, 1);
                chk("grant_num", bus.gnt_num_o, mon_ei);
                chk("grant_onehot", bus.gnt_o, 1 << mon_ei);
            end else if (mon_newg) begin
                chk("grant_unexpected", 1, 0);
            end

            mon_ef = fall_q.size() > 0 && fall_q[0] == cyc;
            if (mon_ef) void'(fall_q.pop_front());
            chk("release", mon_fall, mon_ef);

            mon_ea = abort_q.size() > 0 && abort_q[0] == cyc;
            if (mon_ea) void'(abort_q.pop_front());
            if (bus.abort_o) aborts_seen++;
            chk("abort", bus.abort_o, mon_ea);

            chk("gnt_shape", bus.gnt_o, bus.gnt_val_o ? (1 << bus.gnt_num_o) : 0);
            mon_prev_val = bus.gnt_val_o;
        end
    end

    int b0;
    int a0;
    logic [N-1:0] rnd_req;
    logic [N-1:0] rnd_last;
    int last_div;

    initial begin
        bus.req_i       = '0;
        bus.last_i      = '0;
        bus.res_ready_i = 1'b0;
        #2;
        check_zero("reset");
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Single requester 2, last on third beat; then all request to observe ptr=3.
        b0 = beats_seen;
        step(5'b00100, 5'b00000, 1'b1);
        step(5'b00100, 5'b00000, 1'b1);
        step(5'b00100, 5'b00000, 1'b1);
        step(5'b00100, 5'b00100, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        chk("t1_beats", beats_seen - b0, 3);
        chk("t1_idle", bus.gnt_val_o, 0);
        step(5'b11111, 5'b11111, 1'b1);
        step(5'b11111, 5'b11111, 1'b1);
        chk("t1_ptr", bus.gnt_num_o, 3);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);

        // All requesting, single-beat bursts from a fresh ptr.
        do_reset();
        for (int k = 0; k < 13; k++) step(5'b11111, 5'b11111, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);

        // Owner 1 never raises last: forced release after MAXBEATS, single-requester regrant.
        do_reset();
        step(5'b00010, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        a0 = aborts_seen;
        for (int k = 0; k < 20; k++) step(5'b00010, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        chk("t3_aborts", aborts_seen - a0, 1);

        // Owner 3 withdraws while 0 waits.
        step(5'b01001, 5'b00000, 1'b1);
        step(5'b01001, 5'b00000, 1'b1);
        step(5'b01001, 5'b00000, 1'b1);
        step(5'b00001, 5'b00000, 1'b1);
        step(5'b00001, 5'b00000, 1'b1);
        step(5'b00001, 5'b00000, 1'b1);
        chk("t4_next", bus.gnt_num_o, 0);
        step(5'b00001, 5'b00001, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);

        // Resource stalls for 20 cycles under a grant.
        step(5'b00100, 5'b00000, 1'b0);
        b0 = beats_seen;
        for (int k = 0; k < 20; k++) step(5'b00100, 5'b00000, 1'b0);
        step(5'b00100, 5'b00000, 1'b1);
        chk("t5_stall_beats", beats_seen - b0, 0);
        chk("t5_hold", bus.gnt_val_o, 1);
        step(5'b00100, 5'b00100, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);

        // Move ptr to 4, reset in the middle of owner 4's burst.
        step(5'b01000, 5'b01000, 1'b1);
        step(5'b01000, 5'b01000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b10000, 5'b00000, 1'b1);
        step(5'b10000, 5'b00000, 1'b1);
        chk("t6_owner", bus.gnt_num_o, 4);
        step(5'b10000, 5'b00000, 1'b1);
        do_reset();
        step(5'b10001, 5'b10001, 1'b1);
        step(5'b10001, 5'b10001, 1'b1);
        chk("t6_after_rst", bus.gnt_num_o, 0);
        step(5'b00000, 5'b00000, 1'b1);
        step(5'b00000, 5'b00000, 1'b1);

        // Randomized traffic with occasional long bursts and resets.
        rnd_req = '0;
        for (int c = 0; c < 3000; c++) begin
            last_div = ((c / 500) % 2 == 0) ? 4 : 40;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) rnd_req[b] = ~rnd_req[b];
                rnd_last[b] = ($urandom_range(0, last_div - 1) == 0);
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                rnd_req = '0;
            end else begin
                step(rnd_req, rnd_last, $urandom_range(0, 3) != 0);
            end
        end

        for (int k = 0; k < 4; k++) step(5'b00000, 5'b00000, 1'b1);
        @(negedge clk_i);
        #1;
        chk("queues_drained", beat_q.size() + abort_q.size() + fall_q.size() + gq_cyc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
